// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable data memory: access sizes,
// byte-lane enables, store-lane replication and load extract/extend.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BYTES  = 4;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    function automatic logic [BYTES-1:0] lane_mask(size_e size, logic [1:0] lane);
        case (size)
            SZ_B:    return 4'b0001 << lane;
            SZ_H:    return lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Right-justified store data copied onto every lane it could land in.
    function automatic logic [DATA_W-1:0] store_lanes(size_e size, logic [DATA_W-1:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extract(logic [DATA_W-1:0] word, size_e size,
                                                       logic [1:0] lane, logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    return {{24{b[7] & ~uns}}, b};
            SZ_H:    return {{16{h[15] & ~uns}}, h};
            SZ_W:    return word;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_be_if.sv
// Request/response valid-ready bus between the MEM stage and the data memory.
interface dmem_be_if #(
    parameter int ADDR_W = 32
) ();
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_W-1:0]         req_addr;
    logic [1:0]                req_size;
    logic                      req_unsigned;
    logic [dmem_pkg::DATA_W-1:0] req_wdata;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [dmem_pkg::DATA_W-1:0] resp_rdata;
    logic                      resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_be_ram.sv
// DEPTH x 32-bit word RAM with per-byte write enables and an enabled registered read.
module dmem_be_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [BYTES-1:0]  be,
    input  logic [IDXW-1:0]   idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [BYTES-1:0][7:0] mem [DEPTH];

    // Read only on demand so a stalled response keeps its word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) mem[idx][b] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_be.sv
// Byte-addressed data memory with 1-entry response register and error reporting.
// Define DMEM_INIT_EN to sweep INIT_VAL into every word after reset release.
module dmem_be
    import dmem_pkg::*;
#(
    parameter int          DEPTH    = 1024,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] INIT_VAL = 32'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_be_if.slave   bus,
    output logic       init_done
);

    localparam int IDXW = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr;
    size_e             size;
    logic [1:0]        lane;
    logic              req_err;
    logic              accept;

    logic              resp_valid_reg;
    logic              resp_err_reg;
    logic              load_reg;
    size_e             size_reg;
    logic [1:0]        lane_reg;
    logic              uns_reg;

    logic              init_sweep;
    logic              ram_we;
    logic              ram_re;
    logic [BYTES-1:0]  ram_be;
    logic [IDXW-1:0]   ram_idx;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign addr = bus.req_addr;
    assign size = size_e'(bus.req_size);
    assign lane = addr[1:0];

    always_comb begin
        req_err = 1'b0;
        case (size)
            SZ_H:    req_err = lane[0];
            SZ_W:    req_err = (lane != 2'b00);
            SZ_BAD:  req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ((addr >> (IDXW + 2)) != '0) req_err = 1'b1;
    end

    assign bus.req_ready = init_done && (!resp_valid_reg || bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef DMEM_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e          state_reg;
    logic [IDXW-1:0] cnt_reg;
    logic            init_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    cnt_reg <= cnt_reg + IDXW'(1);
                    if (cnt_reg == IDXW'(DEPTH - 1)) begin
                        state_reg     <= ST_RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_sweep = (state_reg == ST_INIT);
    assign init_done  = init_done_reg;
`else
    logic [31:0] unused_init_val;
    logic [IDXW-1:0] cnt_reg;

    assign unused_init_val = INIT_VAL;
    assign cnt_reg         = '0;
    assign init_sweep      = 1'b0;
    assign init_done       = 1'b1;
`endif

    // The init sweep owns the RAM port; requests are blocked meanwhile.
    always_comb begin
        ram_we    = accept && bus.req_we && !req_err;
        ram_re    = accept && !bus.req_we && !req_err;
        ram_be    = lane_mask(size, lane);
        ram_idx   = addr[IDXW+1:2];
        ram_wdata = store_lanes(size, bus.req_wdata);
        if (init_sweep) begin
            ram_we    = 1'b1;
            ram_re    = 1'b0;
            ram_be    = '1;
            ram_idx   = cnt_reg;
            ram_wdata = INIT_VAL;
        end
    end

    dmem_be_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .be    (ram_be),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            load_reg       <= 1'b0;
            size_reg       <= SZ_W;
            lane_reg       <= 2'b00;
            uns_reg        <= 1'b0;
        end else if (accept) begin
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= req_err;
            load_reg       <= !bus.req_we && !req_err;
            size_reg       <= size;
            lane_reg       <= lane;
            uns_reg        <= bus.req_unsigned;
        end else if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.resp_rdata = load_reg ? load_extract(ram_rdata, size_reg, lane_reg, uns_reg) : '0;

endmodule

// File: tb/tb_dmem_be.sv
// Randomised self-checking bench for dmem_be against a byte-array reference model.
module tb_dmem_be;

`ifdef DMEM_INIT_EN
    localparam int          DEPTH    = 16;
    localparam logic [31:0] INIT_VAL = 32'hDEAD_BEEF;
`else
    localparam int          DEPTH    = 1024;
    localparam logic [31:0] INIT_VAL = 32'h0;
`endif
    localparam int NBYTES = DEPTH * 4;
    localparam int RB     = (NBYTES < 256) ? NBYTES : 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;

    dmem_be_if #(.ADDR_W(32)) bus ();

    dmem_be #(.DEPTH(DEPTH), .ADDR_W(32), .INIT_VAL(INIT_VAL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl [NBYTES];
    bit         vld [NBYTES];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_err(logic [31:0] a, logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        if (a >= 32'(NBYTES)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit mdl_known(logic [31:0] a, logic [1:0] sz);
        for (int i = 0; i < (1 << sz); i++) if (!vld[int'(a) + i]) return 1'b0;
        return 1'b1;
    endfunction

    // Little-endian gather, then two's-complement reinterpretation for signed loads.
    function automatic logic [31:0] mdl_load(logic [31:0] a, logic [1:0] sz, bit uns);
        longint v = 0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) v += longint'(mdl[int'(a) + i]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic mdl_store(logic [31:0] a, logic [1:0] sz, logic [31:0] w);
        for (int i = 0; i < (1 << sz); i++) begin
            mdl[int'(a) + i] = w[8*i +: 8];
            vld[int'(a) + i] = 1'b1;
        end
    endtask

    task automatic mdl_init();
        for (int i = 0; i < NBYTES; i++) begin
`ifdef DMEM_INIT_EN
            mdl[i] = INIT_VAL[8*(i%4) +: 8];
            vld[i] = 1'b1;
`else
            mdl[i] = 8'h00;
            vld[i] = 1'b0;
`endif
        end
    endtask

    task automatic txn(input bit we, input logic [31:0] a, input logic [1:0] sz, input bit uns,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int waitc = 0;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = a;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_wdata    = wd;
        bus.resp_ready   = 1'b1;
        while (!bus.req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        rd  = '0;
        err = 1'b0;
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("resp_valid_latency", 32'(bus.resp_valid), 32'd1);
        rd  = bus.resp_rdata;
        err = bus.resp_err;
    endtask

    task automatic do_op(input bit we, input logic [31:0] a, input logic [1:0] sz, input bit uns,
                         input logic [31:0] wd, input string tag, output logic [31:0] rd);
        logic err;
        bit   exp_err;
        exp_err = mdl_err(a, sz);
        txn(we, a, sz, uns, wd, rd, err);
        $display("txn %s %s a=%08h sz=%0d u=%0d wd=%08h rd=%08h err=%0d",
                 tag, we ? "st" : "ld", a, sz, uns, wd, rd, err);
        check($sformatf("%s_err", tag), 32'(err), 32'(exp_err));
        if (we || exp_err)
            check($sformatf("%s_rdata0", tag), rd, 32'h0);
        else if (mdl_known(a, sz))
            check($sformatf("%s_rdata", tag), rd, mdl_load(a, sz, uns));
        if (we && !exp_err) mdl_store(a, sz, wd);
    endtask

    task automatic wait_init(string tag);
`ifdef DMEM_INIT_EN
        int cyc = 0;
        #1 check($sformatf("%s_init_low", tag), 32'(init_done), 32'd0);
        check($sformatf("%s_ready_low", tag), 32'(bus.req_ready), 32'd0);
        while (!init_done && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        check($sformatf("%s_init_cycles", tag), 32'(cyc), 32'(DEPTH));
        mdl_init();
`else
        #1 check($sformatf("%s_init_done", tag), 32'(init_done), 32'd1);
        check($sformatf("%s_ready", tag), 32'(bus.req_ready), 32'd1);
`endif
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] prior;
        logic [31:0] exp1;
        logic [31:0] exp2;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b1;
        mdl_init();

        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        rst_n = 1'b1;
        wait_init("boot");

`ifdef DMEM_INIT_EN
        do_op(0, 32'h0, 2'd2, 0, 0, "init_ld0", rd);
        check("init_ld0_val", rd, 32'hDEAD_BEEF);
        do_op(0, 32'(NBYTES - 4), 2'd2, 0, 0, "init_ldlast", rd);
        check("init_ldlast_val", rd, 32'hDEAD_BEEF);
`else
        for (int i = 0; i < RB / 4; i++) do_op(1, 32'(i * 4), 2'd2, 0, $urandom, "fill", rd);
`endif

        do_op(1, 32'h10, 2'd2, 0, 32'h1234_5678, "st_w", rd);
        do_op(0, 32'h10, 2'd2, 0, 0, "ld_w", rd);
        check("ld_w_val", rd, 32'h1234_5678);
        do_op(1, 32'h13, 2'd0, 0, 32'h0000_0080, "st_b", rd);
        do_op(0, 32'h13, 2'd0, 0, 0, "ld_bs", rd);
        check("ld_bs_val", rd, 32'hFFFF_FF80);
        do_op(0, 32'h13, 2'd0, 1, 0, "ld_bu", rd);
        check("ld_bu_val", rd, 32'h0000_0080);
        do_op(0, 32'h10, 2'd2, 0, 0, "ld_w2", rd);
        check("ld_w2_val", rd, 32'h8034_5678);
        do_op(0, 32'h12, 2'd1, 0, 0, "ld_hs", rd);
        check("ld_hs_val", rd, 32'hFFFF_8034);

        do_op(0, 32'h20, 2'd2, 0, 0, "ld_prior", prior);
        do_op(1, 32'h21, 2'd1, 0, 32'hA5A5_A5A5, "st_h_mis", rd);
        do_op(0, 32'h20, 2'd2, 0, 0, "ld_after_mis", rd);
        check("mis_unchanged", rd, prior);
        do_op(0, 32'h22, 2'd2, 0, 0, "ld_w_mis", rd);
        do_op(0, 32'h20, 2'd3, 0, 0, "ld_bad_size", rd);
        do_op(0, 32'(NBYTES), 2'd2, 0, 0, "ld_range", rd);
        do_op(1, 32'(NBYTES - 4), 2'd2, 0, 32'hCAFE_F00D, "st_last", rd);
        do_op(0, 32'(NBYTES - 4), 2'd2, 0, 0, "ld_last", rd);

        // Backpressure: hold the response three cycles with a second load queued.
        exp1 = mdl_load(32'h10, 2'd2, 0);
        exp2 = mdl_load(32'h20, 2'd2, 0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_size   = 2'd2;
        bus.resp_ready = 1'b0;
        check("bp_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_addr = 32'h20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(bus.req_ready), 32'd0);
            check("bp_valid", 32'(bus.resp_valid), 32'd1);
            check("bp_rdata", bus.resp_rdata, exp1);
        end
        bus.resp_ready = 1'b1;
        #1 check("bp_ready_release", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("bp_second_valid", 32'(bus.resp_valid), 32'd1);
        check("bp_second_rdata", bus.resp_rdata, exp2);
        @(negedge clk);
        check("bp_valid_fall", 32'(bus.resp_valid), 32'd0);
        $display("txn bp ld a=00000010 then a=00000020 rd=%08h", exp2);

        // Reset while a response is pending.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h10;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        #2 check("rstmid_pending", 32'(bus.resp_valid), 32'd1);
        rst_n = 1'b0;
        #1 check("rstmid_valid", 32'(bus.resp_valid), 32'd0);
        check("rstmid_rdata", bus.resp_rdata, 32'd0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset mid-response");
        wait_init("rerst");
        do_op(0, 32'h10, 2'd2, 0, 0, "ld_retain", rd);

        for (int t = 0; t < 300; t++) begin
            bit          we;
            bit          uns;
            int          r;
            int          m;
            logic [1:0]  sz;
            logic [31:0] a;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            sz  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            m   = int'($urandom_range(0, 19));
            if (m == 0)      a = 32'(NBYTES) + $urandom_range(0, 255);
            else if (m == 1) a = $urandom;
            else begin
                a = $urandom_range(0, RB - 1);
                if (m != 2 && sz == 2'd1) a[0] = 1'b0;
                if (m != 2 && sz == 2'd2) a[1:0] = 2'b00;
            end
            do_op(we, a, sz, uns, $urandom, "rnd", rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_be.md
Name: dmem_be

Overview:
- Parametrised data memory for the pipelined core's MEM stage; next generation of the single-cycle word RAM.
- Byte-addressed, with byte/half/word access sizes, sign or zero extension on loads, and alignment/range error reporting.
- Synchronous 1-cycle read, with a request/response valid-ready handshake and a 1-entry response register.
- Optional power-on initialisation sweep.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, >= 4.
- ADDR_W, 32: request byte-address width.
- INIT_VAL, 32'h0: word written to every location by the init sweep (DMEM_INIT_EN only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal size.
- init_done  out  1  memory usable.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: resp_valid=0, resp_rdata=0, resp_err=0.
  - Without init: init_done=1 and req_ready=1 from the first cycle after reset.
  - RAM contents are not cleared by reset.
- Handshake:
  - req_ready = init_done && (!resp_valid || resp_ready).
  - A request accepted at edge N produces resp_valid=1 after edge N, i.e. 1-cycle latency.
  - Back-to-back accepts, one per cycle, are supported while resp_ready=1.
  - While resp_valid && !resp_ready: req_ready=0, and resp_rdata/resp_err are held stable.
  - resp_valid falls after a consume edge with no new accept.
- Address decode:
  - Word index = req_addr[$clog2(DEPTH)+1:2]; byte lane = req_addr[1:0].
- Error conditions (resp_err=1):
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_addr >= DEPTH*4, where upper address bits are nonzero.
  - On error: no RAM write, resp_rdata=0.
- Stores:
  - Byte-enable write at the accept edge.
  - Byte: lane addr[1:0] <= wdata[7:0].
  - Half: lanes {addr[1],0}+1:{addr[1],0} <= wdata[15:0].
  - Word: all 4 lanes.
  - Other lanes are unchanged.
  - Response: resp_err per the error rules, resp_rdata=0.
- Loads:
  - Word read at the accept edge; lane select and extension are applied into the response register.
  - Byte/half: sign-extend from bit 7/15 unless req_unsigned=1.
  - Word: req_unsigned is ignored.
- Ordering:
  - A load accepted the cycle after a store to the same word returns the post-store value.
  - No same-edge load/store conflict is possible, since there is one port and one request per edge.
- Reset mid-operation:
  - A pending response is dropped (resp_valid=0).
  - A store accepted before reset assertion has completed; RAM otherwise retains its contents.

Optional Feature:
- Macro: DMEM_INIT_EN.
- Defined:
  - After reset release, an FSM in INIT writes INIT_VAL to words 0..DEPTH-1, one per cycle, using a $clog2(DEPTH)-bit counter.
  - init_done=0 and req_ready=0 during the sweep.
  - After the write to word DEPTH-1 the FSM enters RUN; init_done=1 and req_ready follows the normal rule on the next cycle, i.e. DEPTH cycles after reset release.
  - Reset asserted mid-sweep restarts the sweep from 0.
- Undefined:
  - No INIT state or counter; init_done is tied 1; INIT_VAL is unused.

Decomposition:
- Package dmem_pkg:
  - DATA_W=32 and BYTES=4 constants;
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_BAD);
  - function for the lane byte-enable mask;
  - function for load extract/extend.
- Sub-module dmem_be_ram:
  - DEPTH x 4-byte array;
  - posedge write with 4-bit byte enable;
  - registered read;
  - no reset.
- Top-level dmem_be holds the handshake, the decode/error logic and the init FSM.

Test Plan:
- Word store/load: store 0x1234_5678 @0x10, then load word @0x10 -> resp_rdata=0x1234_5678, err=0, resp_valid exactly 1 cycle after accept.
- Byte/half lanes: store byte 0x80 @0x13, then load byte signed @0x13 -> 0xFFFF_FF80; unsigned -> 0x0000_0080; load word @0x10 -> 0x8034_5678.
- Misaligned: store half @0x21 -> err=1, RAM unchanged (word @0x20 reads its prior value); load word @0x22 -> err=1, rdata=0; size=11 -> err=1.
- Range: DEPTH=1024, load @0x1000 -> err=1.
- Backpressure: hold resp_ready=0 for 3 cycles after a load -> req_ready=0 and resp stable; then release -> next request accepted in the same cycle as the consume.
- Reset/init: assert rst_n=0 with resp_valid=1 -> resp_valid=0 immediately.
  - With DMEM_INIT_EN, DEPTH=16, INIT_VAL=0xDEAD_BEEF: init_done rises 16 cycles after release, and any load returns 0xDEAD_BEEF.
